// File: rtl/dev_gpio_bank.sv
// dev_gpio_bank: parametrised GPIO bank on the hs32 peripheral bus.
// Synchronised inputs, atomic output ops and sticky edge interrupts.
module dev_gpio_bank #(
    parameter int NUM_IO      = 32,
    parameter int PAD_OFFSET  = 6,
    parameter int PADS        = 38,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PADS-1:0]   io_in,
    output logic [PADS-1:0]   io_out,
    output logic [PADS-1:0]   io_oeb,
    output logic [NUM_IO-1:0] io_in_sync,
    input  logic              stb,
    output logic              ack,
    input  logic              rw,
    input  logic [3:0]        addr,
    input  logic [31:0]       dwrite,
    output logic [31:0]       dread,
    output logic              irq_rise,
    output logic              irq_fall
);
    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int CW      = $clog2(ARM_MAX + 1);

    localparam logic [3:0] A_OEB   = 4'd0;
    localparam logic [3:0] A_OUT   = 4'd1;
    localparam logic [3:0] A_SET   = 4'd2;
    localparam logic [3:0] A_CLR   = 4'd3;
    localparam logic [3:0] A_TGL   = 4'd4;
    localparam logic [3:0] A_IN    = 4'd5;
    localparam logic [3:0] A_REN   = 4'd6;
    localparam logic [3:0] A_FEN   = 4'd7;
    localparam logic [3:0] A_RPEND = 4'd8;
    localparam logic [3:0] A_FPEND = 4'd9;

    typedef logic [NUM_IO-1:0] io_t;

    io_t           oeb_q;
    io_t           out_q;
    io_t           rise_en_q;
    io_t           fall_en_q;
    io_t           rise_pend_q;
    io_t           fall_pend_q;
    io_t           sync_q [SYNC_STAGES];
    io_t           prev_q;
    logic [CW-1:0] arm_cnt;
    logic          armed;
    logic          accept;
    logic          wr;
    io_t           wdata;
    io_t           rise;
    io_t           fall;
    io_t           rise_w1c;
    io_t           fall_w1c;
    logic [31:0]   rdata;
    logic          unused_bits;

    assign accept     = stb & ~ack;
    assign wr         = accept & rw;
    assign wdata      = dwrite[NUM_IO-1:0];
    assign armed      = (arm_cnt == CW'(ARM_MAX));
    assign io_in_sync = sync_q[SYNC_STAGES-1];

    // Edges only count on input pins once the synchroniser has settled.
    assign rise = io_in_sync & ~prev_q & oeb_q & {NUM_IO{armed}};
    assign fall = ~io_in_sync & prev_q & oeb_q & {NUM_IO{armed}};

    assign rise_w1c = (wr && addr == A_RPEND) ? wdata : '0;
    assign fall_w1c = (wr && addr == A_FPEND) ? wdata : '0;

    assign irq_rise = |(rise_pend_q & rise_en_q);
    assign irq_fall = |(fall_pend_q & fall_en_q);

    assign unused_bits = ^{io_in, dwrite};

    always_comb begin
        rdata = '0;
        case (addr)
            A_OEB:   rdata = 32'(oeb_q);
            A_OUT:   rdata = 32'(out_q);
            A_IN:    rdata = 32'(io_in_sync);
            A_REN:   rdata = 32'(rise_en_q);
            A_FEN:   rdata = 32'(fall_en_q);
            A_RPEND: rdata = 32'(rise_pend_q);
            A_FPEND: rdata = 32'(fall_pend_q);
            default: rdata = '0;
        endcase
    end

    always_comb begin
        io_out = '0;
        io_oeb = '1;
        io_out[PAD_OFFSET +: NUM_IO] = out_q;
        io_oeb[PAD_OFFSET +: NUM_IO] = oeb_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q  <= '0;
            arm_cnt <= '0;
        end else begin
            sync_q[0] <= io_in[PAD_OFFSET +: NUM_IO];
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= io_in_sync;
            if (!armed) begin
                arm_cnt <= arm_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            oeb_q       <= '1;
            out_q       <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            rise_pend_q <= '0;
            fall_pend_q <= '0;
            ack         <= 1'b0;
            dread       <= '0;
        end else begin
            // A new edge beats a same-cycle clear so no event is lost.
            rise_pend_q <= (rise_pend_q & ~rise_w1c) | rise;
            fall_pend_q <= (fall_pend_q & ~fall_w1c) | fall;
            ack         <= accept;
            if (accept && !rw) begin
                dread <= rdata;
            end
            if (wr) begin
                case (addr)
                    A_OEB:   oeb_q     <= wdata;
                    A_OUT:   out_q     <= wdata;
                    A_SET:   out_q     <= out_q | wdata;
                    A_CLR:   out_q     <= out_q & ~wdata;
                    A_TGL:   out_q     <= out_q ^ wdata;
                    A_REN:   rise_en_q <= wdata;
                    A_FEN:   fall_en_q <= wdata;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dev_gpio_bank.sv
// tb_dev_gpio_bank: scoreboard bench for two GPIO bank configurations
// (32 bits at pad 6, 8 bits at pad 30) sharing clock, reset and pads.
module tb_dev_gpio_bank;
    localparam int S    = 2;
    localparam int PADS = 38;

    typedef struct {
        bit          rd;
        logic [31:0] exp;
        string       nm;
    } txn_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [PADS-1:0] io_in = '0;
    logic [PADS-1:0] io_out0, io_oeb0, io_out1, io_oeb1;
    logic [31:0]     sync0;
    logic [7:0]      sync1;
    logic            stb0 = 0, rw0 = 0, stb1 = 0, rw1 = 0;
    logic [3:0]      addr0 = '0, addr1 = '0;
    logic [31:0]     dw0 = '0, dw1 = '0;
    logic            ack0, ack1, irqr0, irqf0, irqr1, irqf1;
    logic [31:0]     dr0, dr1;

    int n_run = 0;
    int n_fail = 0;
    txn_t q0[$];
    txn_t q1[$];

    int          off[2] = '{6, 30};
    int          nio[2] = '{32, 8};
    logic [31:0] msk[2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    logic [31:0] m_oeb[2], m_out[2], m_ren[2], m_fen[2], m_rp[2], m_fp[2];

    always #5 clk = ~clk;

    dev_gpio_bank u0 (
        .clk(clk), .reset(reset), .io_in(io_in), .io_out(io_out0),
        .io_oeb(io_oeb0), .io_in_sync(sync0), .stb(stb0), .ack(ack0),
        .rw(rw0), .addr(addr0), .dwrite(dw0), .dread(dr0),
        .irq_rise(irqr0), .irq_fall(irqf0)
    );

    dev_gpio_bank #(.NUM_IO(8), .PAD_OFFSET(30)) u1 (
        .clk(clk), .reset(reset), .io_in(io_in), .io_out(io_out1),
        .io_oeb(io_oeb1), .io_in_sync(sync1), .stb(stb1), .ack(ack1),
        .rw(rw1), .addr(addr1), .dwrite(dw1), .dread(dr1),
        .irq_rise(irqr1), .irq_fall(irqf1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pins(int d, logic [PADS-1:0] p);
        return 32'(p >> off[d]) & msk[d];
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_oeb[d] = msk[d];
            m_out[d] = '0;
            m_ren[d] = '0;
            m_fen[d] = '0;
            m_rp[d]  = '0;
            m_fp[d]  = '0;
        end
    endfunction

    function automatic logic [31:0] m_read(int d, logic [3:0] a);
        case (a)
            4'd0:    return m_oeb[d];
            4'd1:    return m_out[d];
            4'd5:    return pins(d, io_in);
            4'd6:    return m_ren[d];
            4'd7:    return m_fen[d];
            4'd8:    return m_rp[d];
            4'd9:    return m_fp[d];
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_write(int d, logic [3:0] a, logic [31:0] v);
        logic [31:0] x;
        x = v & msk[d];
        case (a)
            4'd0: m_oeb[d] = x;
            4'd1: m_out[d] = x;
            4'd2: m_out[d] = m_out[d] | x;
            4'd3: m_out[d] = m_out[d] & ~x;
            4'd4: m_out[d] = m_out[d] ^ x;
            4'd6: m_ren[d] = x;
            4'd7: m_fen[d] = x;
            4'd8: m_rp[d]  = m_rp[d] & ~x;
            4'd9: m_fp[d]  = m_fp[d] & ~x;
            default: ;
        endcase
    endfunction

    function automatic void model_edges(logic [PADS-1:0] ov, logic [PADS-1:0] nv);
        logic [31:0] o, n;
        for (int d = 0; d < 2; d++) begin
            o = pins(d, ov);
            n = pins(d, nv);
            m_rp[d] = m_rp[d] | (n & ~o & m_oeb[d]);
            m_fp[d] = m_fp[d] | (o & ~n & m_oeb[d]);
        end
    endfunction

    function automatic logic [PADS-1:0] exp_pads(int d, logic [31:0] v, bit fill);
        logic [PADS-1:0] r;
        for (int p = 0; p < PADS; p++) begin
            if (p >= off[d] && p - off[d] < nio[d]) r[p] = v[p-off[d]];
            else r[p] = fill;
        end
        return r;
    endfunction

    task automatic mon(input int d, input logic [31:0] dr);
        txn_t t;
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL spurious_ack dut%0d: got ack expected none", d);
        end else begin
            t = (d == 0) ? q0.pop_front() : q1.pop_front();
            if (t.rd) chk(t.nm, dr, t.exp);
        end
    endtask

    always @(negedge clk) begin
        if (ack0) mon(0, dr0);
        if (ack1) mon(1, dr1);
    end

    task automatic bus(input int d, input bit w, input logic [3:0] a,
                       input logic [31:0] data, input string nm, input bit hold = 0);
        txn_t t;
        @(negedge clk);
        t.rd = !w;
        t.exp = m_read(d, a);
        t.nm = nm;
        if (d == 0) begin
            stb0 = 1; rw0 = w; addr0 = a; dw0 = data; q0.push_back(t);
        end else begin
            stb1 = 1; rw1 = w; addr1 = a; dw1 = data; q1.push_back(t);
        end
        @(posedge clk); #1;
        if (hold) begin
            @(posedge clk); #1;
        end
        stb0 = 0;
        stb1 = 0;
        if (w) m_write(d, a, data);
        @(negedge clk); #1;
        chk({nm, "_ack"}, (d == 0) ? q0.size() : q1.size(), 0);
    endtask

    task automatic set_pads(input logic [PADS-1:0] nv);
        logic [PADS-1:0] ov;
        ov = io_in;
        @(posedge clk); #1;
        io_in = nv;
        model_edges(ov, nv);
        repeat (S + 3) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        model_reset();
        repeat (S + 4) @(posedge clk);
    endtask

    task automatic check_outputs(input string nm);
        chk({nm, "_out0"}, io_out0, exp_pads(0, m_out[0], 0));
        chk({nm, "_oeb0"}, io_oeb0, exp_pads(0, m_oeb[0], 1));
        chk({nm, "_out1"}, io_out1, exp_pads(1, m_out[1], 0));
        chk({nm, "_oeb1"}, io_oeb1, exp_pads(1, m_oeb[1], 1));
        chk({nm, "_irq0"}, {irqr0, irqf0},
            {|(m_rp[0] & m_ren[0]), |(m_fp[0] & m_fen[0])});
        chk({nm, "_irq1"}, {irqr1, irqf1},
            {|(m_rp[1] & m_ren[1]), |(m_fp[1] & m_fen[1])});
    endtask

    initial begin
        logic [PADS-1:0] ov;
        bit found;
        int d, a;
        bit w;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_oeb0", io_oeb0, {PADS{1'b1}});
        chk("rst_out0", io_out0, '0);
        chk("rst_oeb1", io_oeb1, {PADS{1'b1}});
        chk("rst_ack_dread", {ack0, ack1, dr0}, '0);
        @(negedge clk);
        reset = 0;
        repeat (S + 4) @(posedge clk);

        bus(0, 0, 0, 0, "rd_oeb0");
        bus(0, 0, 1, 0, "rd_out0");
        bus(1, 0, 0, 0, "rd_oeb1");
        check_outputs("post_rst");

        bus(0, 1, 0, 32'h0, "wr_oeb");
        bus(0, 1, 1, 32'h0000_00F0, "wr_out");
        bus(0, 1, 2, 32'h0000_0001, "wr_set");
        bus(0, 1, 3, 32'h0000_0010, "wr_clr");
        bus(0, 1, 4, 32'h8000_0000, "wr_tgl");
        bus(0, 1, 2, 32'h0, "wr_set0");
        bus(0, 0, 1, 0, "rd_out_atomic");
        chk("atomic_pads", io_out0[37:6], 32'h8000_00E1);
        check_outputs("atomic");

        set_pads(io_in | (38'd1 << 10));
        bus(0, 0, 8, 0, "rd_rpend_masked");

        bus(0, 1, 0, 32'hFFFF_FFFF, "wr_oeb_in");
        bus(0, 1, 6, 32'h4, "wr_ren");
        ov = io_in;
        @(posedge clk); #1;
        io_in[8] = 1'b1;
        model_edges(ov, io_in);
        found = 0;
        for (int i = 0; i < S + 2 && !found; i++) begin
            @(negedge clk);
            if (irqr0) found = 1;
        end
        chk("irq_rise_latency", found, 1);
        repeat (2) @(posedge clk);
        bus(0, 0, 8, 0, "rd_rpend");
        bus(0, 1, 8, 32'h4, "w1c_rpend");
        chk("irq_rise_clr", irqr0, |(m_rp[0] & m_ren[0]));

        bus(0, 1, 7, 32'h8, "wr_fen");
        set_pads(io_in | (38'd1 << 9));
        set_pads(io_in & ~(38'd1 << 9));
        chk("irq_fall_set", irqf0, |(m_fp[0] & m_fen[0]));
        set_pads(io_in | (38'd1 << 9));
        ov = io_in;
        @(posedge clk); #1;
        io_in[9] = 1'b0;
        repeat (S) @(posedge clk);
        bus(0, 1, 9, 32'h8, "w1c_collide");
        model_edges(ov, io_in);
        bus(0, 0, 9, 0, "rd_fpend_collide");
        chk("irq_fall_collide", irqf0, |(m_fp[0] & m_fen[0]));

        bus(0, 0, 1, 0, "rd_out_hold", 1);
        bus(0, 0, 5, 0, "rd_in");
        bus(0, 0, 12, 0, "rd_unmapped");

        bus(1, 1, 0, 32'h0, "n8_wr_oeb");
        bus(1, 1, 1, 32'hFFFF_FFFF, "n8_wr_out");
        bus(1, 0, 1, 0, "n8_rd_out");
        chk("n8_pads", io_out1[37:30], 8'hFF);
        check_outputs("n8");

        for (int i = 0; i < 60; i++) begin
            d = $urandom_range(0, 1);
            a = $urandom_range(0, 15);
            w = 1'($urandom_range(0, 1));
            bus(d, w, 4'(a), $urandom, $sformatf("rnd%0d_d%0d_a%0d", i, d, a));
        end
        check_outputs("rnd");
        chk("sync0", sync0, pins(0, io_in));

        set_pads(io_in | 38'd1 << 6 | 38'h3 << 30);
        do_reset();
        bus(0, 0, 8, 0, "arm_rpend0");
        bus(1, 0, 8, 0, "arm_rpend1");
        bus(0, 0, 0, 0, "arm_oeb0");
        check_outputs("arm");
        set_pads(io_in & ~(38'd1 << 6));
        bus(0, 0, 9, 0, "arm_fpend0");
        set_pads(io_in | (38'd1 << 6));
        bus(0, 0, 8, 0, "arm_rpend_live");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
